// File: rtl/add64_arb_pkg.sv
// Shared types and helpers for the add64 arbiter: FSM state encoding, datapath width,
// and the round-robin successor function.
package add64_arb_pkg;

  localparam int unsigned ADD_W = 64;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StResp   = 2'd2
  } arb_state_e;

  // Next index after idx in a ring of n entries.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request after ptr,
// wrapping modulo NUM_REQ. Outputs a one-hot grant (or zero) and its index.
module rr_arbiter
  import add64_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  int unsigned idx;
  logic        found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = rr_next(32'(ptr), NUM_REQ);
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && req[idx[ID_W-1:0]]) begin
        found                  = 1'b1;
        grant[idx[ID_W-1:0]]   = 1'b1;
        grant_idx              = idx[ID_W-1:0];
      end
      idx = rr_next(idx, NUM_REQ);
    end
  end

endmodule

// File: rtl/add64_arbiter.sv
// Round-robin sequencer sharing one external 64-bit adder among NUM_REQ requesters.
// Define ADD64_ARB_OVF_EN to capture the adder overflow flag into resp_ovf.
module add64_arbiter
  import add64_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = 4,
  parameter  int unsigned SETTLE_CYC = 2,
  localparam int unsigned ID_W       = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*ADD_W-1:0] req_a,
  input  logic [NUM_REQ*ADD_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_cin,
  output logic [ADD_W-1:0]         add_a,
  output logic [ADD_W-1:0]         add_b,
  output logic                     add_cin,
  input  logic [ADD_W-1:0]         add_sum,
  input  logic                     add_cout,
  input  logic                     add_ovf,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ID_W-1:0]          resp_id,
  output logic [ADD_W-1:0]         resp_sum,
  output logic                     resp_cout,
  output logic                     resp_ovf,
  output logic                     busy
);

  localparam int unsigned     CntW    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(SETTLE_CYC - 1);
  localparam logic [ID_W-1:0] PtrInit = ID_W'(NUM_REQ - 1);

  arb_state_e         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [ID_W-1:0]    ptr_q, id_q, grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic               resp_valid_q, resp_valid_d;
  logic               accept, capture;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .req      (req_valid),
    .ptr      (ptr_q),
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    accept       = 1'b0;
    capture      = 1'b0;
    req_ready    = '0;
    case (state_q)
      StIdle: begin
        req_ready = grant;
        if (|grant) begin
          accept  = 1'b1;
          cnt_d   = CntInit;
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == '0) begin
          capture      = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = StResp;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      ptr_q        <= PtrInit;
      id_q         <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      if (accept) begin
        ptr_q <= grant_idx;
        id_q  <= grant_idx;
      end
    end
  end

  // Operands hold between transfers so the adder inputs stay quiet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_a   <= '0;
      add_b   <= '0;
      add_cin <= 1'b0;
    end else if (accept) begin
      add_a   <= req_a[ADD_W*grant_idx +: ADD_W];
      add_b   <= req_b[ADD_W*grant_idx +: ADD_W];
      add_cin <= req_cin[grant_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_sum  <= '0;
      resp_cout <= 1'b0;
    end else if (capture) begin
      resp_sum  <= add_sum;
      resp_cout <= add_cout;
    end
  end

`ifdef ADD64_ARB_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (capture) begin
      ovf_q <= add_ovf;
    end
  end

  assign resp_ovf = ovf_q;
`else
  logic unused_ovf;

  assign unused_ovf = add_ovf;
  assign resp_ovf   = 1'b0;
`endif

  assign resp_valid = resp_valid_q;
  assign resp_id    = id_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_add64_arbiter.sv
// Directed bench for add64_arbiter with a behavioural adder model on each instance.
module tb_add64_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned S = 2;
`ifdef ADD64_ARB_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic            clk, rst;
  logic [N-1:0]    req_valid, req_cin, req_ready;
  logic [N*64-1:0] req_a, req_b;
  logic            resp_ready;
  logic [63:0]     add_a, add_b, add_sum, resp_sum;
  logic            add_cin, add_cout, add_ovf, resp_valid, resp_cout, resp_ovf, busy;
  logic [1:0]      resp_id;
  logic [64:0]     m_res;

  logic [N-1:0]    s1_req_valid, s1_req_ready, s4_req_valid, s4_req_ready;
  logic [63:0]     s1_add_a, s1_add_b, s1_add_sum, s1_resp_sum;
  logic [63:0]     s4_add_a, s4_add_b, s4_add_sum, s4_resp_sum;
  logic            s1_add_cin, s1_add_cout, s1_add_ovf, s1_resp_valid, s1_resp_ready;
  logic            s4_add_cin, s4_add_cout, s4_add_ovf, s4_resp_valid, s4_resp_ready;
  logic            s1_resp_cout, s1_resp_ovf, s1_busy, s4_resp_cout, s4_resp_ovf, s4_busy;
  logic [1:0]      s1_resp_id, s4_resp_id;
  logic [64:0]     s1_res, s4_res;

  int n_vec = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder models: ovf flags signed overflow of the low 32-bit half.
  assign m_res    = {1'b0, add_a} + {1'b0, add_b} + 65'(add_cin);
  assign add_sum  = m_res[63:0];
  assign add_cout = m_res[64];
  assign add_ovf  = (add_a[31] == add_b[31]) && (add_sum[31] != add_a[31]);
  assign s1_res      = {1'b0, s1_add_a} + {1'b0, s1_add_b} + 65'(s1_add_cin);
  assign s1_add_sum  = s1_res[63:0];
  assign s1_add_cout = s1_res[64];
  assign s1_add_ovf  = (s1_add_a[31] == s1_add_b[31]) && (s1_add_sum[31] != s1_add_a[31]);
  assign s4_res      = {1'b0, s4_add_a} + {1'b0, s4_add_b} + 65'(s4_add_cin);
  assign s4_add_sum  = s4_res[63:0];
  assign s4_add_cout = s4_res[64];
  assign s4_add_ovf  = (s4_add_a[31] == s4_add_b[31]) && (s4_add_sum[31] != s4_add_a[31]);

  add64_arbiter #(.NUM_REQ(N), .SETTLE_CYC(S)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout), .add_ovf(add_ovf),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_sum(resp_sum), .resp_cout(resp_cout), .resp_ovf(resp_ovf), .busy(busy)
  );

  add64_arbiter #(.NUM_REQ(N), .SETTLE_CYC(1)) dut_s1 (
    .clk(clk), .rst(rst), .req_valid(s1_req_valid), .req_ready(s1_req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .add_a(s1_add_a), .add_b(s1_add_b), .add_cin(s1_add_cin),
    .add_sum(s1_add_sum), .add_cout(s1_add_cout), .add_ovf(s1_add_ovf),
    .resp_valid(s1_resp_valid), .resp_ready(s1_resp_ready), .resp_id(s1_resp_id),
    .resp_sum(s1_resp_sum), .resp_cout(s1_resp_cout), .resp_ovf(s1_resp_ovf), .busy(s1_busy)
  );

  add64_arbiter #(.NUM_REQ(N), .SETTLE_CYC(4)) dut_s4 (
    .clk(clk), .rst(rst), .req_valid(s4_req_valid), .req_ready(s4_req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .add_a(s4_add_a), .add_b(s4_add_b), .add_cin(s4_add_cin),
    .add_sum(s4_add_sum), .add_cout(s4_add_cout), .add_ovf(s4_add_ovf),
    .resp_valid(s4_resp_valid), .resp_ready(s4_resp_ready), .resp_id(s4_resp_id),
    .resp_sum(s4_resp_sum), .resp_cout(s4_resp_cout), .resp_ovf(s4_resp_ovf), .busy(s4_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b,
                         input logic c);
    req_a[64*i +: 64] = a;
    req_b[64*i +: 64] = b;
    req_cin[i]        = c;
  endtask

  task automatic accept(input int id);
    logic [N-1:0] exp_oh;
    exp_oh = N'(1) << id;
    #1;
    chk("req_ready_grant", 64'(req_ready), 64'(exp_oh));
    tick();
    chk("busy_after_accept", 64'(busy), 64'(1));
  endtask

  task automatic wait_resp();
    int   cyc;
    logic rdy_seen;
    cyc      = 0;
    rdy_seen = 1'b0;
    while (resp_valid !== 1'b1 && cyc < 20) begin
      if (req_ready !== '0) rdy_seen = 1'b1;
      tick();
      cyc++;
    end
    if (req_ready !== '0) rdy_seen = 1'b1;
    chk("latency", 64'(cyc), 64'(S));
    chk("req_ready_outside_idle", 64'(rdy_seen), 64'(0));
  endtask

  task automatic check_resp(input int id, input logic [63:0] sum, input logic cout,
                            input logic ovf);
    chk("resp_valid", 64'(resp_valid), 64'(1));
    chk("resp_id", 64'(resp_id), 64'(id));
    chk("resp_sum", resp_sum, sum);
    chk("resp_cout", 64'(resp_cout), 64'(cout));
    chk("resp_ovf", 64'(resp_ovf), 64'(ovf));
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("resp_valid_after_hs", 64'(resp_valid), 64'(0));
    chk("busy_after_hs", 64'(busy), 64'(0));
  endtask

  initial begin
    int   cyc;
    logic bad;
    rst = 1'b1; req_valid = '0; req_cin = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
    s1_req_valid = '0; s4_req_valid = '0; s1_resp_ready = 1'b0; s4_resp_ready = 1'b0;
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_add_a", add_a, 64'h0);
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    rst = 1'b0;

    // Single request: all-ones + 1 wraps to zero with carry out.
    set_req(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    req_valid = 4'b0001;
    accept(0);
    req_valid = '0;
    chk("add_a_registered", add_a, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_resp();
    check_resp(0, 64'h0, 1'b1, 1'b0);
    handshake();

    // All four valid from a fresh pointer: 0,1,2,3,0.
    rst = 1'b1; #1; rst = 1'b0;
    set_req(0, 64'h10, 64'h1, 1'b1);
    set_req(1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
    set_req(2, 64'h0000_0001_0000_0000, 64'h0000_0002_0000_0005, 1'b0);
    set_req(3, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b1);
    req_valid = 4'b1111;
    accept(0); wait_resp(); check_resp(0, 64'h12, 1'b0, 1'b0); handshake();
    accept(1); wait_resp(); check_resp(1, 64'h0, 1'b1, 1'b0); handshake();
    accept(2); wait_resp(); check_resp(2, 64'h0000_0003_0000_0005, 1'b0, 1'b0); handshake();
    accept(3); wait_resp(); check_resp(3, 64'h2345_6789_ABCD_F002, 1'b0, 1'b0); handshake();
    accept(0); wait_resp(); check_resp(0, 64'h12, 1'b0, 1'b0); handshake();

    // Low-half signed overflow.
    set_req(0, 64'h7FFF_FFFF_7FFF_FFFF, 64'h1, 1'b0);
    req_valid = 4'b0001;
    accept(0);
    req_valid = '0;
    wait_resp();
    check_resp(0, 64'h7FFF_FFFF_8000_0000, 1'b0, OVF_EXP);
    handshake();

    // Backpressure with requester 2 pending.
    set_req(0, 64'h5, 64'h6, 1'b0);
    req_valid = 4'b0001;
    accept(0);
    req_valid = 4'b0100;
    wait_resp();
    check_resp(0, 64'hB, 1'b0, 1'b0);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (resp_valid !== 1'b1 || resp_sum !== 64'hB || resp_id !== 2'd0 ||
          req_ready !== '0 || busy !== 1'b1) bad = 1'b1;
    end
    chk("backpressure_stable", 64'(bad), 64'(0));
    handshake();
    accept(2);
    req_valid = '0;
    chk("resp_sum_kept_after_hs", resp_sum, 64'hB);
    chk("add_a_req2", add_a, 64'h0000_0001_0000_0000);
    wait_resp();
    check_resp(2, 64'h0000_0003_0000_0005, 1'b0, 1'b0);
    handshake();

    // Reset mid-SETTLE, then fairness between 1 and 3.
    req_valid = 4'b0001;
    accept(0);
    req_valid = '0;
    tick();
    chk("still_settling", 64'(busy), 64'(1));
    rst = 1'b1;
    #1;
    chk("rst_mid_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_mid_busy", 64'(busy), 64'(0));
    chk("rst_mid_add_a", add_a, 64'h0);
    chk("rst_mid_resp_sum", resp_sum, 64'h0);
    tick();
    rst = 1'b0;
    req_valid = 4'b1010;
    accept(1); wait_resp(); check_resp(1, 64'h0, 1'b1, 1'b0); handshake();
    accept(3); wait_resp(); check_resp(3, 64'h2345_6789_ABCD_F002, 1'b0, 1'b0); handshake();
    accept(1); wait_resp(); check_resp(1, 64'h0, 1'b1, 1'b0); handshake();
    req_valid = '0;

    // Latency with SETTLE_CYC = 1.
    s1_req_valid = 4'b0001;
    #1;
    chk("s1_req_ready", 64'(s1_req_ready), 64'(1));
    tick();
    s1_req_valid = '0;
    cyc = 0; bad = 1'b0;
    while (s1_resp_valid !== 1'b1 && cyc < 20) begin
      if (s1_req_ready !== '0) bad = 1'b1;
      tick();
      cyc++;
    end
    chk("s1_latency", 64'(cyc), 64'(1));
    chk("s1_ready_outside_idle", 64'(bad), 64'(0));
    chk("s1_resp_sum", s1_resp_sum, 64'hB);
    s1_resp_ready = 1'b1; tick(); s1_resp_ready = 1'b0;
    chk("s1_resp_valid_after_hs", 64'(s1_resp_valid), 64'(0));

    // Latency with SETTLE_CYC = 4.
    s4_req_valid = 4'b0001;
    #1;
    chk("s4_req_ready", 64'(s4_req_ready), 64'(1));
    tick();
    s4_req_valid = '0;
    cyc = 0; bad = 1'b0;
    while (s4_resp_valid !== 1'b1 && cyc < 20) begin
      if (s4_req_ready !== '0) bad = 1'b1;
      tick();
      cyc++;
    end
    chk("s4_latency", 64'(cyc), 64'(4));
    chk("s4_ready_outside_idle", 64'(bad), 64'(0));
    chk("s4_resp_sum", s4_resp_sum, 64'hB);
    s4_resp_ready = 1'b1; tick(); s4_resp_ready = 1'b0;
    chk("s4_resp_valid_after_hs", 64'(s4_resp_valid), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
